// File: rtl/scratchpad_resp_pkg.sv
// rtl/scratchpad_resp_pkg.sv - shared types and op encodings for the scratchpad responder
package scratchpad_resp_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } spr_state_t;

  // Width-independent part of the latched request; wide fields live in the top.
  typedef struct packed {
    logic [1:0] op;
    logic       err;
  } spr_req_t;

  function automatic logic op_is_legal(input logic [1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with its own priority pointer
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             found;
  int               j;

  // Search from the pointer upward with wrap; first valid requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!found && en_i && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

  // Next pointer sits just past the port that was granted.
  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      if (int'(idx_o) == N - 1) ptr_d = '0;
      else                      ptr_d = idx_o + IDX_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dcache_scratchpad_responder.sv
// rtl/dcache_scratchpad_responder.sv - fixed-latency scratchpad standing in for the dCache
module dcache_scratchpad_responder
  import scratchpad_resp_pkg::*;
#(
  parameter int                NREQUESTERS = 2,
  parameter int                ADDR_W      = 40,
  parameter int                DATA_W      = 64,
  parameter int                TID_W       = 6,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                LATENCY     = 2,
  localparam int               BE_W        = DATA_W / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQUESTERS-1:0] req_valid_i,
  output logic [NREQUESTERS-1:0] req_ready_o,
  input  logic [ADDR_W-1:0]      req_addr_i  [NREQUESTERS],
  input  logic [1:0]             req_op_i    [NREQUESTERS],
  input  logic [DATA_W-1:0]      req_wdata_i [NREQUESTERS],
  input  logic [BE_W-1:0]        req_be_i    [NREQUESTERS],
  input  logic [TID_W-1:0]       req_tid_i   [NREQUESTERS],
  output logic [NREQUESTERS-1:0] rsp_valid_o,
  output logic [DATA_W-1:0]      rsp_rdata_o [NREQUESTERS],
  output logic [TID_W-1:0]       rsp_tid_o   [NREQUESTERS],
  output logic [NREQUESTERS-1:0] rsp_error_o,
  output logic                   wbuf_empty_o
);

  localparam int OFF_W  = $clog2(BE_W);
  localparam int WIDX_W = $clog2(DEPTH_WORDS);
  localparam int PIDX_W = (NREQUESTERS > 1) ? $clog2(NREQUESTERS) : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  spr_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PIDX_W-1:0] port_q;
  spr_req_t          meta_q;
  logic [WIDX_W-1:0] widx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [TID_W-1:0]  tid_q;

  logic [NREQUESTERS-1:0] rsp_valid_q;
  logic [DATA_W-1:0]      rsp_rdata_q;
  logic [TID_W-1:0]       rsp_tid_q;
  logic                   rsp_err_q;

  logic                   arb_en;
  logic [NREQUESTERS-1:0] gnt;
  logic [PIDX_W-1:0]      gnt_idx;
  logic                   accept;

  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] sel_off;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic [TID_W-1:0]  sel_tid;
  logic              sel_err;
  logic [WIDX_W-1:0] sel_widx;

  logic              enter_resp_d;
  logic [PIDX_W-1:0] src_port_d;
  logic [1:0]        src_op_d;
  logic              src_err_d;
  logic [WIDX_W-1:0] src_widx_d;
  logic [TID_W-1:0]  src_tid_d;

  assign arb_en      = (state_q == IDLE) && !rst_i;
  assign req_ready_o = gnt;
  assign accept      = |gnt;

  rr_arbiter #(.N(NREQUESTERS)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_valid_i),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // Pick the granted request and decode its word index and error flag.
  always_comb begin
    sel_addr  = req_addr_i[gnt_idx];
    sel_op    = req_op_i[gnt_idx];
    sel_wdata = req_wdata_i[gnt_idx];
    sel_be    = req_be_i[gnt_idx];
    sel_tid   = req_tid_i[gnt_idx];
    sel_off   = sel_addr - BASE_ADDR;
    sel_widx  = sel_off[OFF_W +: WIDX_W];
    sel_err   = !((sel_addr >= BASE_ADDR) && ((sel_off >> (OFF_W + WIDX_W)) == '0))
                || !op_is_legal(sel_op);
  end

  // Response source: the live request when LATENCY==1, otherwise the latched one.
  always_comb begin
    enter_resp_d = ((state_q == IDLE) && accept && (LATENCY == 1))
                   || ((state_q == WAIT) && (cnt_q == '0));
    if (state_q == IDLE) begin
      src_port_d = gnt_idx;
      src_op_d   = sel_op;
      src_err_d  = sel_err;
      src_widx_d = sel_widx;
      src_tid_d  = sel_tid;
    end else begin
      src_port_d = port_q;
      src_op_d   = meta_q.op;
      src_err_d  = meta_q.err;
      src_widx_d = widx_q;
      src_tid_d  = tid_q;
    end
  end

  // Main FSM: accept, count down the latency, present a one-cycle response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      port_q      <= '0;
      meta_q      <= '0;
      widx_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      tid_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_tid_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            port_q     <= gnt_idx;
            meta_q.op  <= sel_op;
            meta_q.err <= sel_err;
            widx_q     <= sel_widx;
            wdata_q    <= sel_wdata;
            be_q       <= sel_be;
            tid_q      <= sel_tid;
            if (LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= '0;
          rsp_rdata_q <= '0;
          rsp_tid_q   <= '0;
          rsp_err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      if (enter_resp_d) begin
        rsp_valid_q             <= '0;
        rsp_valid_q[src_port_d] <= 1'b1;
        rsp_rdata_q             <= ((src_op_d == OP_LOAD) && !src_err_d) ? mem_q[src_widx_d] : '0;
        rsp_tid_q               <= src_tid_d;
        rsp_err_q               <= src_err_d;
      end
    end
  end

  // Byte-wise store into the scratchpad during the RESP cycle; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == RESP) && (meta_q.op == OP_STORE) && !meta_q.err) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_q[b]) mem_q[widx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // Fan the shared response registers out, zeroed on ports not being answered.
  always_comb begin
    rsp_valid_o = rsp_valid_q;
    for (int p = 0; p < NREQUESTERS; p++) begin
      rsp_rdata_o[p] = rsp_valid_q[p] ? rsp_rdata_q : '0;
      rsp_tid_o[p]   = rsp_valid_q[p] ? rsp_tid_q : '0;
      rsp_error_o[p] = rsp_valid_q[p] & rsp_err_q;
    end
  end

  assign wbuf_empty_o = !((accept && (sel_op == OP_STORE))
                          || ((state_q != IDLE) && (meta_q.op == OP_STORE)));

endmodule

// File: tb/tb_dcache_scratchpad_responder.sv
// tb/tb_dcache_scratchpad_responder.sv - scoreboard bench for the scratchpad responder
module tb_dcache_scratchpad_responder;

  localparam int         LAT  = 2;
  localparam logic [39:0] BASE = 40'h10_0000_0000;
  localparam logic [1:0] LD = 2'b00;
  localparam logic [1:0] ST = 2'b01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   acc [8];
  bit   lat_done [2];

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [39:0] req_addr  [2];
  logic [1:0]  req_op    [2];
  logic [63:0] req_wdata [2];
  logic [7:0]  req_be    [2];
  logic [5:0]  req_tid   [2];
  logic [1:0]  rsp_valid;
  logic [63:0] rsp_rdata [2];
  logic [5:0]  rsp_tid   [2];
  logic [1:0]  rsp_error;
  logic        wbuf_empty;

  typedef struct {
    int          port;
    logic [5:0]  tid;
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_scratchpad_responder #(
    .NREQUESTERS(2), .ADDR_W(40), .DATA_W(64), .TID_W(6),
    .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .LATENCY(LAT)
  ) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_op_i(req_op), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .req_tid_i(req_tid),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_tid_o(rsp_tid),
    .rsp_error_o(rsp_error), .wbuf_empty_o(wbuf_empty)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic drive(input int p, input logic [1:0] op, input logic [39:0] addr,
                       input logic [63:0] wdata, input logic [7:0] be, input logic [5:0] tid,
                       input logic [63:0] exp_rdata, input logic exp_err, input bit push,
                       output int acc_edge);
    exp_t e;
    req_addr[p] = addr; req_op[p] = op; req_wdata[p] = wdata;
    req_be[p] = be; req_tid[p] = tid; req_valid[p] = 1'b1;
    acc_edge = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (req_ready[p]) begin
        acc_edge = cyc + 1;
        if (push) begin
          e.port = p; e.tid = tid; e.rdata = exp_rdata; e.err = exp_err; e.cyc = cyc + LAT;
          sb.push_back(e);
        end
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    req_valid[p] = 1'b0;
    if (acc_edge < 0) check("grant_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0) break;
    end
    check("drain", 64'(sb.size()), 64'(0));
    @(negedge clk);
  endtask

  // Monitor: pop and compare on every response pulse.
  always @(negedge clk) begin : mon
    exp_t       e;
    logic [1:0] ev;
    if (!rst && (rsp_valid != 2'b00)) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        ev = 2'b00;
        ev[e.port] = 1'b1;
        check("rsp_port", 64'(rsp_valid), 64'(ev));
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
        check("rsp_tid", 64'(rsp_tid[e.port]), 64'(e.tid));
        check("rsp_rdata", rsp_rdata[e.port], e.rdata);
        check("rsp_error", 64'(rsp_error[e.port]), 64'(e.err));
        check("idle_port_zero", {rsp_rdata[1-e.port][31:0], 24'(rsp_tid[1-e.port]),
                                 8'(rsp_error[1-e.port])}, 64'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      req_addr[p] = '0; req_op[p] = LD; req_wdata[p] = '0; req_be[p] = '0; req_tid[p] = '0;
    end
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", 64'(req_ready), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_error", 64'(rsp_error), 64'(0));
    check("reset_rsp_data", rsp_rdata[0] | rsp_rdata[1], 64'(0));
    check("reset_rsp_tid", 64'(rsp_tid[0] | rsp_tid[1]), 64'(0));
    check("reset_wbuf_empty", 64'(wbuf_empty), 64'(1));
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous requests from reset: port 0 first, port 1 three cycles later.
    fork
      drive(0, ST, BASE + 40'h100, 64'hA0A0_A0A0_0000_0001, 8'hFF, 6'd1, 64'h0, 1'b0, 1'b1, acc[0]);
      drive(1, ST, BASE + 40'h108, 64'hA1A1_A1A1_0000_0002, 8'hFF, 6'd2, 64'h0, 1'b0, 1'b1, acc[1]);
    join
    check("first_pair_spacing", 64'(acc[1] - acc[0]), 64'(3));
    drain();

    // Both held valid: grants alternate 0,1,0,1.
    fork
      begin
        drive(0, LD, BASE + 40'h100, 64'h0, 8'h00, 6'd3, 64'hA0A0_A0A0_0000_0001, 1'b0, 1'b1, acc[0]);
        drive(0, LD, BASE + 40'h108, 64'h0, 8'h00, 6'd5, 64'hA1A1_A1A1_0000_0002, 1'b0, 1'b1, acc[2]);
      end
      begin
        drive(1, LD, BASE + 40'h108, 64'h0, 8'h00, 6'd4, 64'hA1A1_A1A1_0000_0002, 1'b0, 1'b1, acc[1]);
        drive(1, LD, BASE + 40'h100, 64'h0, 8'h00, 6'd6, 64'hA0A0_A0A0_0000_0001, 1'b0, 1'b1, acc[3]);
      end
    join
    check("alt_spacing_01", 64'(acc[1] - acc[0]), 64'(3));
    check("alt_spacing_12", 64'(acc[2] - acc[1]), 64'(3));
    check("alt_spacing_23", 64'(acc[3] - acc[2]), 64'(3));
    drain();

    // Store then load the same word; write buffer busy while the store is in flight.
    drive(0, ST, BASE + 40'h40, 64'hDEAD_BEEF_0123_4567, 8'hFF, 6'd5, 64'h0, 1'b0, 1'b1, acc[0]);
    #1;
    check("wbuf_wait", 64'(wbuf_empty), 64'(0));
    @(negedge clk); #1;
    check("wbuf_resp", 64'(wbuf_empty), 64'(0));
    @(negedge clk); #1;
    check("wbuf_after", 64'(wbuf_empty), 64'(1));
    @(negedge clk);
    drive(0, LD, BASE + 40'h40, 64'h0, 8'h00, 6'd6, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1, acc[0]);
    drive(1, LD, BASE + 40'h47, 64'h0, 8'h00, 6'd7, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1, acc[0]);
    drain();

    // Errors: out of range above/below, illegal op; word 0 stays intact.
    drive(1, ST, BASE, 64'h1111_2222_3333_4444, 8'hFF, 6'd10, 64'h0, 1'b0, 1'b1, acc[0]);
    drive(1, ST, BASE + 40'h1FF8, 64'h5A5A_0000_0000_A5A5, 8'hFF, 6'd11, 64'h0, 1'b0, 1'b1, acc[0]);
    drive(0, LD, BASE + 40'h2000, 64'h0, 8'h00, 6'd12, 64'h0, 1'b1, 1'b1, acc[0]);
    drive(0, 2'b10, BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 6'd13, 64'h0, 1'b1, 1'b1, acc[0]);
    drive(1, ST, BASE - 40'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 6'd14, 64'h0, 1'b1, 1'b1, acc[0]);
    drive(0, LD, BASE, 64'h0, 8'h00, 6'd15, 64'h1111_2222_3333_4444, 1'b0, 1'b1, acc[0]);
    drive(1, LD, BASE + 40'h1FF8, 64'h0, 8'h00, 6'd16, 64'h5A5A_0000_0000_A5A5, 1'b0, 1'b1, acc[0]);
    drain();

    // Partial byte enables.
    drive(0, ST, BASE + 40'h80, 64'h0, 8'hFF, 6'd20, 64'h0, 1'b0, 1'b1, acc[0]);
    drive(0, ST, BASE + 40'h80, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 6'd21, 64'h0, 1'b0, 1'b1, acc[0]);
    drive(1, LD, BASE + 40'h80, 64'h0, 8'h00, 6'd22, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1, acc[0]);
    drain();

    // Reset while a store waits: no response, no write, pointer back to 0.
    drive(0, ST, BASE + 40'h40, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 6'd30, 64'h0, 1'b0, 1'b0, acc[0]);
    rst = 1'b1;
    @(negedge clk); #1;
    check("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midreset_rsp_data", rsp_rdata[0] | rsp_rdata[1], 64'(0));
    check("midreset_rsp_tid", 64'(rsp_tid[0] | rsp_tid[1]), 64'(0));
    check("midreset_rsp_error", 64'(rsp_error), 64'(0));
    check("midreset_wbuf", 64'(wbuf_empty), 64'(1));
    rst = 1'b0;
    repeat (4) @(negedge clk);
    fork
      drive(1, LD, BASE + 40'h100, 64'h0, 8'h00, 6'd32, 64'hA0A0_A0A0_0000_0001, 1'b0, 1'b1, acc[1]);
      drive(0, LD, BASE + 40'h40, 64'h0, 8'h00, 6'd31, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1, acc[0]);
    join
    check("midreset_ptr_spacing", 64'(acc[1] - acc[0]), 64'(3));
    drain();

    for (int k = 0; k < 200; k++) begin
      if (lat_done[0] && lat_done[1]) break;
      @(negedge clk);
    end
    check("latency_benches_done", 64'({lat_done[0], lat_done[1]}), 64'(2'b11));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Extra instances exercising LATENCY=1 and LATENCY=5 timing.
  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int L = (g == 0) ? 1 : 5;
    logic [1:0]  v;
    logic [1:0]  rdy;
    logic [39:0] a  [2];
    logic [1:0]  o  [2];
    logic [63:0] wd [2];
    logic [7:0]  be [2];
    logic [5:0]  t  [2];
    logic [1:0]  rv;
    logic [63:0] rd [2];
    logic [5:0]  rt [2];
    logic [1:0]  re;
    logic        we;

    dcache_scratchpad_responder #(.LATENCY(L)) u_lat (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(v), .req_ready_o(rdy),
      .req_addr_i(a), .req_op_i(o), .req_wdata_i(wd), .req_be_i(be), .req_tid_i(t),
      .rsp_valid_o(rv), .rsp_rdata_o(rd), .rsp_tid_o(rt), .rsp_error_o(re),
      .wbuf_empty_o(we)
    );

    initial begin
      int lacc [2];
      int lrc  [2];
      int na;
      int nr;
      na = 0; nr = 0;
      lacc[0] = 0; lacc[1] = 0; lrc[0] = 0; lrc[1] = 0;
      v = 2'b00;
      for (int p = 0; p < 2; p++) begin
        a[p] = '0; o[p] = LD; wd[p] = '0; be[p] = '0; t[p] = 6'(g + 40);
      end
      @(negedge clk);
      while (rst) @(negedge clk);
      v[0] = 1'b1;
      for (int k = 0; k < 60; k++) begin
        #1;
        if (v[0] && rdy[0] && na < 2) begin
          lacc[na] = cyc + 1;
          na++;
        end
        if (rv[0] && nr < 2) begin
          lrc[nr] = cyc;
          nr++;
          check("lat_rsp_tid", 64'(rt[0]), 64'(g + 40));
        end
        @(negedge clk);
        if (na == 2) v[0] = 1'b0;
        if (na == 2 && nr == 2) break;
      end
      check("lat_accepts", 64'(na), 64'(2));
      check("lat_responses", 64'(nr), 64'(2));
      check("lat_spacing", 64'(lacc[1] - lacc[0]), 64'(L + 1));
      check("lat_rsp0_cycle", 64'(lrc[0]), 64'(lacc[0] + L - 1));
      check("lat_rsp1_cycle", 64'(lrc[1]), 64'(lacc[1] + L - 1));
      lat_done[g] = 1'b1;
    end
  end

endmodule
